// File: rtl/voice_increment_sequencer_if.sv
// Note/increment bus between the key decoder, the voice sequencer and the
// per-voice sample address generators.
interface voice_increment_sequencer_if #(
    parameter int VOICES = 4,
    parameter int LEN_W  = 16
);
    localparam int VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic              init;
    logic              sample_clk;
    logic              new_note;
    logic [VIDX_W-1:0] note_voice;
    logic [LEN_W-1:0]  note_len;
    logic              note_off;
    logic [VIDX_W-1:0] off_voice;
    logic              increment;
    logic [VIDX_W-1:0] inc_voice;
    logic              voice_done;
    logic              frame_done;
    logic [VOICES-1:0] active;
    logic              overrun;

    modport master (
        output init, sample_clk, new_note, note_voice, note_len, note_off, off_voice,
        input  increment, inc_voice, voice_done, frame_done, active, overrun
    );

    modport slave (
        input  init, sample_clk, new_note, note_voice, note_len, note_off, off_voice,
        output increment, inc_voice, voice_done, frame_done, active, overrun
    );
endinterface

// File: rtl/voice_increment_sequencer.sv
// Multi-voice sample increment sequencer: one scan over all voices per
// sample-clock rising edge, one increment strobe per active voice.
module voice_increment_sequencer #(
    parameter int VOICES = 4,
    parameter int LEN_W  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    voice_increment_sequencer_if.slave  bus
);
    localparam int VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ARMED      = 2'd1,
        S_SCAN       = 2'd2,
        S_FRAME_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [VIDX_W-1:0] r_idx;
    logic [VIDX_W-1:0] w_idx_nxt;
    logic [VOICES-1:0] r_active;
    logic [VOICES-1:0] w_active_nxt;
    logic [LEN_W-1:0]  r_remaining [VOICES];
    logic [LEN_W-1:0]  w_remaining_nxt [VOICES];
    logic              r_sclk_q;
    logic              r_overrun;
    logic              w_overrun_nxt;

    logic              w_edge;
    logic              w_live;
    logic              w_restart;
    logic              w_load;
    logic              w_scan_hit;
    logic              w_retire;
    logic              w_done;

    assign w_edge     = bus.sample_clk & ~r_sclk_q;
    assign w_live     = (r_state != S_IDLE);
    assign w_restart  = w_live & bus.init;
    assign w_load     = w_live & ~bus.init & bus.new_note & (bus.note_len != LEN_W'(0));
    assign w_scan_hit = (r_state == S_SCAN) & r_active[r_idx];
    assign w_retire   = w_scan_hit & (r_remaining[r_idx] == LEN_W'(1));
    // A reload of the voice being retired this cycle wins, so its done pulse must be withheld now.
    assign w_done     = w_retire & ~(w_load & (bus.note_voice == r_idx));

    // Next-state logic for the scan FSM, voice bitmap, counters and overrun flag.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_active_nxt  = r_active;
        w_overrun_nxt = r_overrun;
        for (int v = 0; v < VOICES; v++) begin
            w_remaining_nxt[v] = r_remaining[v];
        end

        if (w_restart) begin
            w_state_nxt   = S_ARMED;
            w_idx_nxt     = '0;
            w_active_nxt  = '0;
            w_overrun_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_idx_nxt = '0;
                    if (bus.init) begin
                        w_state_nxt = S_ARMED;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ARMED: begin
                    w_idx_nxt = '0;
                    if (w_edge) begin
                        w_state_nxt = S_SCAN;
                    end else begin
                        w_state_nxt = S_ARMED;
                    end
                end
                S_SCAN: begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_FRAME_DONE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_SCAN;
                        w_idx_nxt   = r_idx + VIDX_W'(1);
                    end
                    // Edges arriving mid-frame are dropped, only remembered as overrun.
                    w_overrun_nxt = r_overrun | w_edge;
                end
                S_FRAME_DONE: begin
                    w_state_nxt   = S_ARMED;
                    w_idx_nxt     = '0;
                    w_overrun_nxt = r_overrun | w_edge;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase

            // Per-voice priority: reload, then kill, then scan decrement/retire.
            for (int v = 0; v < VOICES; v++) begin
                if (w_load && (bus.note_voice == VIDX_W'(v))) begin
                    w_active_nxt[v]    = 1'b1;
                    w_remaining_nxt[v] = bus.note_len;
                end else if (w_live && bus.note_off && (bus.off_voice == VIDX_W'(v))) begin
                    w_active_nxt[v]    = 1'b0;
                end else if (w_scan_hit && (r_idx == VIDX_W'(v))) begin
                    w_remaining_nxt[v] = r_remaining[v] - LEN_W'(1);
                    w_active_nxt[v]    = (r_remaining[v] != LEN_W'(1));
                end else begin
                    w_active_nxt[v]    = r_active[v];
                end
            end
        end
    end

    // State, index, voice and flag registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_active  <= '0;
            r_sclk_q  <= 1'b0;
            r_overrun <= 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                r_remaining[v] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_active  <= w_active_nxt;
            r_sclk_q  <= bus.sample_clk;
            r_overrun <= w_overrun_nxt;
            for (int v = 0; v < VOICES; v++) begin
                r_remaining[v] <= w_remaining_nxt[v];
            end
        end
    end

    assign bus.increment  = w_scan_hit;
    assign bus.inc_voice  = (r_state == S_SCAN) ? r_idx : '0;
    assign bus.voice_done = w_done;
    assign bus.frame_done = (r_state == S_FRAME_DONE);
    assign bus.active     = r_active;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_voice_increment_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// cycle by cycle against a frame-timing model of the sequencer.
module tb_voice_increment_sequencer;
    localparam int VOICES = 4;
    localparam int LEN_W  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    voice_increment_sequencer_if #(.VOICES(VOICES), .LEN_W(LEN_W)) bus ();
    voice_increment_sequencer #(.VOICES(VOICES), .LEN_W(LEN_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: frame start time plus per-voice note bookkeeping
    bit m_started;
    int m_frame_t;
    bit m_prev_sclk;
    bit m_ovr;
    bit m_act [VOICES];
    int m_rem [VOICES];

    // Sample clock generator: period 0 = low, negative = held high
    int sc_per = 0;
    int sc_ph  = 0;

    int n_inc  [VOICES];
    int n_done [VOICES];
    int n_frames;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_started   = 1'b0;
        m_frame_t   = -100;
        m_prev_sclk = 1'b0;
        m_ovr       = 1'b0;
        for (int v = 0; v < VOICES; v++) begin
            m_act[v] = 1'b0;
            m_rem[v] = 0;
        end
    endtask

    task automatic clear_counts();
        n_frames = 0;
        for (int v = 0; v < VOICES; v++) begin
            n_inc[v]  = 0;
            n_done[v] = 0;
        end
    endtask

    // One clock cycle: apply sample clock, check outputs, advance model, clear strobes.
    task automatic run_cycle();
        int k;
        bit in_scan, in_fd, busy, load, edge_s, exp_inc, exp_done;
        logic [VOICES-1:0] exp_act;
        if (sc_per > 0) begin
            bus.sample_clk = (sc_ph == 0);
            sc_ph = (sc_ph + 1) % sc_per;
        end else begin
            bus.sample_clk = (sc_per < 0);
        end
        #1;
        k       = cyc - m_frame_t - 1;
        in_scan = m_started && k >= 0 && k < VOICES;
        in_fd   = m_started && k == VOICES;
        busy    = m_started && k >= 0 && k <= VOICES;
        load    = m_started && !bus.init && bus.new_note && (bus.note_len != 0);
        exp_inc = in_scan && m_act[k];
        exp_done = exp_inc && (m_rem[k] == 1) && !(load && int'(bus.note_voice) == k);
        for (int v = 0; v < VOICES; v++) exp_act[v] = m_act[v];

        check_val("increment",  bus.increment,  exp_inc);
        check_val("inc_voice",  bus.inc_voice,  in_scan ? k : 0);
        check_val("voice_done", bus.voice_done, exp_done);
        check_val("frame_done", bus.frame_done, in_fd);
        check_val("active",     bus.active,     exp_act);
        check_val("overrun",    bus.overrun,    m_ovr);

        if (bus.increment)  n_inc[bus.inc_voice]++;
        if (bus.voice_done) n_done[bus.inc_voice]++;
        if (bus.frame_done) n_frames++;

        edge_s = bus.sample_clk && !m_prev_sclk;
        if (rst) begin
            model_reset();
        end else begin
            if (!m_started) begin
                if (bus.init) m_started = 1'b1;
            end else if (bus.init) begin
                for (int v = 0; v < VOICES; v++) m_act[v] = 1'b0;
                m_ovr     = 1'b0;
                m_frame_t = cyc - 100;
            end else begin
                if (edge_s) begin
                    if (busy) m_ovr = 1'b1;
                    else      m_frame_t = cyc;
                end
                if (in_scan && m_act[k]) begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) m_act[k] = 1'b0;
                end
                if (bus.note_off) m_act[bus.off_voice] = 1'b0;
                if (load) begin
                    m_act[bus.note_voice] = 1'b1;
                    m_rem[bus.note_voice] = int'(bus.note_len);
                end
            end
            m_prev_sclk = bus.sample_clk;
        end
        cyc++;
        @(posedge clk);
        #1;
        bus.init     = 1'b0;
        bus.new_note = 1'b0;
        bus.note_off = 1'b0;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run_n(2);
        rst = 1'b0;
    endtask

    task automatic do_init();
        bus.init = 1'b1;
        run_cycle();
    endtask

    task automatic note(input int v, input int len);
        bus.new_note   = 1'b1;
        bus.note_voice = v[1:0];
        bus.note_len   = len[LEN_W-1:0];
        run_cycle();
    endtask

    // Advance until the next cycle is the scan slot of voice kk, bounded.
    task automatic wait_slot(input int kk);
        int guard = 0;
        while (!(m_started && (cyc - m_frame_t - 1) == kk) && guard < 200) begin
            run_cycle();
            guard++;
        end
        check_val("wait_slot_bound", guard < 200, 1'b1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.init       = 1'b0;
        bus.sample_clk = 1'b0;
        bus.new_note   = 1'b0;
        bus.note_voice = '0;
        bus.note_len   = '0;
        bus.note_off   = 1'b0;
        bus.off_voice  = '0;
        @(posedge clk);
        #1;
        model_reset();
        clear_counts();

        // Single voice, length 3, four edges
        do_reset();
        do_init();
        note(2, 3);
        clear_counts();
        sc_per = 10; sc_ph = 0;
        run_n(40);
        sc_per = 0;
        run_n(5);
        check_val("s1_strobes_v2", n_inc[2], 3);
        check_val("s1_done_v2", n_done[2], 1);
        check_val("s1_frames", n_frames, 4);
        check_val("s1_active_end", bus.active, 4'b0000);

        // Two voices, lengths 2 and 5
        note(0, 2);
        note(3, 5);
        clear_counts();
        sc_per = 10; sc_ph = 0;
        run_n(50);
        sc_per = 0;
        run_n(5);
        check_val("s2_strobes_v0", n_inc[0], 2);
        check_val("s2_strobes_v3", n_inc[3], 5);
        check_val("s2_done_v0", n_done[0], 1);
        check_val("s2_done_v3", n_done[3], 1);

        // Reload colliding with the final decrement of voice 1
        note(1, 1);
        clear_counts();
        sc_per = 10; sc_ph = 0;
        wait_slot(1);
        bus.new_note = 1'b1; bus.note_voice = 2'd1; bus.note_len = 16'd4;
        run_cycle();
        check_val("s3_no_done_at_reload", n_done[1], 0);
        run_n(60);
        sc_per = 0;
        run_n(5);
        check_val("s3_strobes_v1", n_inc[1], 5);
        check_val("s3_done_v1", n_done[1], 1);

        // note_off mid-note, then new_note and note_off together
        note(0, 5);
        clear_counts();
        sc_per = 10; sc_ph = 0;
        run_n(15);
        bus.note_off = 1'b1; bus.off_voice = 2'd0;
        run_cycle();
        run_n(25);
        sc_per = 0;
        run_n(5);
        check_val("s4_strobes_before_off", n_inc[0], 2);
        check_val("s4_no_done_after_off", n_done[0], 0);
        check_val("s4_active0_off", bus.active[0], 1'b0);
        bus.new_note = 1'b1; bus.note_voice = 2'd0; bus.note_len = 16'd6;
        bus.note_off = 1'b1; bus.off_voice  = 2'd0;
        run_cycle();
        check_val("s4_newnote_wins", bus.active[0], 1'b1);
        clear_counts();
        sc_per = 10; sc_ph = 0;
        run_n(70);
        sc_per = 0;
        run_n(5);
        check_val("s4_strobes_v0", n_inc[0], 6);
        check_val("s4_done_v0", n_done[0], 1);

        // Sample clock too fast for a full frame
        note(2, 50);
        sc_per = 5; sc_ph = 0;
        run_n(20);
        check_val("s5_overrun_set", bus.overrun, 1'b1);
        sc_per = 0;
        do_init();
        check_val("s5_overrun_cleared", bus.overrun, 1'b0);
        check_val("s5_active_cleared", bus.active, 4'b0000);

        // Notes ignored in IDLE and with zero length
        do_reset();
        note(1, 3);
        do_init();
        note(2, 0);
        clear_counts();
        sc_per = 10; sc_ph = 0;
        run_n(30);
        check_val("s6_no_strobes", n_inc[0] + n_inc[1] + n_inc[2] + n_inc[3], 0);
        check_val("s6_active_zero", bus.active, 4'b0000);

        // Held-high sample clock yields a single edge
        note(3, 4);
        clear_counts();
        sc_per = -1;
        run_n(30);
        check_val("s7_single_edge", n_inc[3], 1);
        sc_per = 0;
        run_n(3);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                sc_per = (($urandom % 16) == 0) ? -1 : int'($urandom_range(4, 14));
                sc_ph  = 0;
            end
            rst = (($urandom % 500) == 0);
            if (($urandom % 8) == 0) begin
                bus.new_note   = 1'b1;
                bus.note_voice = 2'($urandom_range(0, VOICES - 1));
                bus.note_len   = 16'($urandom_range(0, 6));
            end
            if (($urandom % 16) == 0) begin
                bus.note_off  = 1'b1;
                bus.off_voice = 2'($urandom_range(0, VOICES - 1));
            end
            if (($urandom % 120) == 0) bus.init = 1'b1;
            run_cycle();
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
